// File: rtl/sync_queue.sv
// Single-clock first-word-fall-through queue on a circular buffer with head/tail/count state.
// Supports a same-cycle flush (kill) and a conservative look-ahead write-ready (wready_next).
module sync_queue #(
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned QUEUE_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 kill,
  output logic                 wready,
  output logic                 wready_next,
  input  logic                 wvalid,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 rready,
  output logic                 rvalid,
  output logic [DATA_SIZE-1:0] rdata
);

  localparam int unsigned PtrW = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(QUEUE_SIZE);

  logic [DATA_SIZE-1:0] mem_q [QUEUE_SIZE];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic wr_en;
  logic rd_en;
  logic mem_we;
  logic [CntW-1:0] count_after_wr;

  // Handshake qualifiers; both depend only on registered state plus the strobes.
  always_comb begin
    rvalid = (count_q != '0);
    rdata  = mem_q[head_q];
    wready = (count_q < FullCount);
    wr_en  = wvalid && wready;
    rd_en  = rvalid && rready;
  end

  // Pops in this cycle are ignored on purpose so the flag never over-promises.
  always_comb begin
    count_after_wr = count_q + CntW'(wr_en);
    wready_next    = kill || (count_after_wr < FullCount);
  end

  // Pointers are power-of-two sized, so natural overflow performs the wrap.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_we  = 1'b0;
    if (kill) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) begin
        tail_d = tail_q + PtrW'(1);
        mem_we = 1'b1;
      end
      if (rd_en) begin
        head_d = head_q + PtrW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[tail_q] <= wdata;
    end
  end

endmodule

// File: tb/tb_sync_queue.sv
// Directed bench for sync_queue at DATA_SIZE=8, QUEUE_SIZE=4 with hand-computed expectations.
module tb_sync_queue;

  logic       clk;
  logic       reset;
  logic       kill;
  logic       wready;
  logic       wready_next;
  logic       wvalid;
  logic [7:0] wdata;
  logic       rready;
  logic       rvalid;
  logic [7:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;

  sync_queue #(
    .DATA_SIZE (8),
    .QUEUE_SIZE(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .kill       (kill),
    .wready     (wready),
    .wready_next(wready_next),
    .wvalid     (wvalid),
    .wdata      (wdata),
    .rready     (rready),
    .rvalid     (rvalid),
    .rdata      (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    #0;
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    kill   = 1'b0;
    wvalid = 1'b0;
    wdata  = 8'h00;
    rready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_wready", 32'(wready), 32'd1);
    chk("rst_wready_next", 32'(wready_next), 32'd1);

    // Three writes, no reads
    wvalid = 1'b1; wdata = 8'h11; #1;
    chk("w1_wready_next", 32'(wready_next), 32'd1);
    tick();
    chk("w1_visible", 32'(rvalid), 32'd1);
    wdata = 8'h22; tick();
    wdata = 8'h33; #1;
    chk("w3_wready_next", 32'(wready_next), 32'd1);
    tick();
    wvalid = 1'b0; #1;
    chk("w3_rvalid", 32'(rvalid), 32'd1);
    chk("w3_rdata", 32'(rdata), 32'h11);
    chk("w3_wready", 32'(wready), 32'd1);
    chk("w3_wready_next_idle", 32'(wready_next), 32'd1);
    // Probe count==3: one more write would fill the queue
    wvalid = 1'b1; wdata = 8'h44; #1;
    chk("cnt3_probe_wready_next", 32'(wready_next), 32'd0);
    wvalid = 1'b0;

    rready = 1'b1; #1;
    chk("drain_0", 32'(rdata), 32'h11); tick();
    chk("drain_1", 32'(rdata), 32'h22); tick();
    chk("drain_2", 32'(rdata), 32'h33); tick();
    chk("drain_empty", 32'(rvalid), 32'd0);
    tick();
    chk("pop_empty_rvalid", 32'(rvalid), 32'd0);
    chk("pop_empty_wready", 32'(wready), 32'd1);
    rready = 1'b0;

    // Fill
    wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wdata = 8'hA0 + 8'(i); #1;
      if (i == 3) begin
        chk("fill_last_wready", 32'(wready), 32'd1);
        chk("fill_last_wready_next", 32'(wready_next), 32'd0);
      end
      tick();
    end
    wvalid = 1'b0; #1;
    chk("full_wready", 32'(wready), 32'd0);
    chk("full_wready_next", 32'(wready_next), 32'd0);
    chk("full_rdata", 32'(rdata), 32'hA0);

    // Dropped write while full, then write blocked during the first pop
    wvalid = 1'b1; wdata = 8'hFF; tick();
    chk("drop_wready", 32'(wready), 32'd0);
    rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_pop_rdata", 32'(rdata), 32'(8'hA0 + 8'(i)));
      tick();
      wvalid = 1'b0;
    end
    chk("full_pop_empty", 32'(rvalid), 32'd0);
    rready = 1'b0;

    // Simultaneous write and pop at count 1
    wvalid = 1'b1; wdata = 8'h55; tick();
    chk("c1_rdata", 32'(rdata), 32'h55);
    wdata = 8'h66; rready = 1'b1; tick();
    wvalid = 1'b0; rready = 1'b0; #1;
    chk("c1_swap_rvalid", 32'(rvalid), 32'd1);
    chk("c1_swap_rdata", 32'(rdata), 32'h66);
    rready = 1'b1; tick();
    chk("c1_count_one", 32'(rvalid), 32'd0);

    // Streaming with wrap-around
    wvalid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wdata = 8'hC0 + 8'(k); #1;
      if (k >= 1) chk("stream_rdata", 32'(rdata), 32'(8'hC0 + 8'(k - 1)));
      tick();
    end
    wvalid = 1'b0; #1;
    chk("stream_last", 32'(rdata), 32'hC9);
    tick();
    chk("stream_empty", 32'(rvalid), 32'd0);
    rready = 1'b0;

    // Kill with count 3 and a concurrent write
    wvalid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wdata = 8'(i); tick();
    end
    kill = 1'b1; wdata = 8'h77; #1;
    chk("kill_wready_next", 32'(wready_next), 32'd1);
    chk("kill_rvalid_pre", 32'(rvalid), 32'd1);
    chk("kill_rdata_pre", 32'(rdata), 32'h01);
    tick();
    kill = 1'b0; wvalid = 1'b0; #1;
    chk("kill_rvalid_post", 32'(rvalid), 32'd0);
    chk("kill_wready_post", 32'(wready), 32'd1);
    wvalid = 1'b1; wdata = 8'h88; tick();
    wvalid = 1'b0; #1;
    chk("post_kill_rdata", 32'(rdata), 32'h88);
    rready = 1'b1; tick();
    chk("post_kill_empty", 32'(rvalid), 32'd0);
    rready = 1'b0;

    // Mid-operation reset with write and pop requested
    wvalid = 1'b1; wdata = 8'h5A; tick();
    wdata = 8'h5B; tick();
    reset = 1'b1; wdata = 8'h5C; rready = 1'b1; tick();
    reset = 1'b0; wvalid = 1'b0; rready = 1'b0; #1;
    chk("mid_reset_rvalid", 32'(rvalid), 32'd0);
    chk("mid_reset_wready_next", 32'(wready_next), 32'd1);
    wvalid = 1'b1; wdata = 8'h3C; tick();
    wvalid = 1'b0; #1;
    chk("after_reset_rdata", 32'(rdata), 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
